ex_mem_pipeline_register: RTL and testbench

EX/MEM pipeline register of the 5-stage RISC-V pipeline CPU. It sits between the execute stage (ALU) and the memory stage. On each rising clock edge it captures the EX-stage control bits, the ALU result, the store data (OUT2), the destination register index and funct3. While the data memory raises BUSYWAIT, it freezes its contents so the pipeline stalls.

---
 rtl/ex_mem_pipeline_register_pkg.sv | 13 +
 rtl/ex_mem_pipeline_register_pipe_reg_en.sv | 15 +
 rtl/ex_mem_pipeline_register.sv | 49 ++++
 tb/tb_ex_mem_pipeline_register.sv | 113 +++++++++++
 4 files changed

// File: rtl/ex_mem_pipeline_register_pkg.sv
// ex_mem_pipeline_register_pkg: shared CPU widths and funct3 load/store encodings
package ex_mem_pipeline_register_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int FUNCT3_WIDTH   = 3;
  typedef enum logic [FUNCT3_WIDTH-1:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_ls_e;
endpackage

// File: rtl/ex_mem_pipeline_register_pipe_reg_en.sv
// pipe_reg_en: width-parameterised flop with async active-low clear and hold enable
module pipe_reg_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  // Clear on reset; otherwise load only when enabled, else hold.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_o <= '0;
    else if (en) q_o <= d_i;
endmodule

// File: rtl/ex_mem_pipeline_register.sv
// ex_mem_pipeline_register: EX/MEM pipeline register that freezes while memory is busy
module ex_mem_pipeline_register
  import ex_mem_pipeline_register_pkg::*;
#(
  parameter int DATA_WIDTH     = ex_mem_pipeline_register_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = ex_mem_pipeline_register_pkg::REG_ADDR_WIDTH,
  parameter int FUNCT3_WIDTH   = ex_mem_pipeline_register_pkg::FUNCT3_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      WRITE_ENABLE_IN,
  input  logic                      MUXDATAMEM_SELECT_IN,
  input  logic                      MEM_READ_IN,
  input  logic                      MEM_WRITE_IN,
  input  logic [DATA_WIDTH-1:0]     ALU_OUT_IN,
  input  logic [DATA_WIDTH-1:0]     OUT2_IN,
  input  logic [REG_ADDR_WIDTH-1:0] RD_IN,
  input  logic [FUNCT3_WIDTH-1:0]   FUNCT3_IN,
  output logic                      WRITE_ENABLE_OUT,
  output logic                      MUXDATAMEM_SELECT_OUT,
  output logic                      MEM_READ_OUT,
  output logic                      MEM_WRITE_OUT,
  output logic [DATA_WIDTH-1:0]     ALU_OUT_OUT,
  output logic [DATA_WIDTH-1:0]     OUT2_OUT,
  output logic [REG_ADDR_WIDTH-1:0] RD_OUT,
  output logic [FUNCT3_WIDTH-1:0]   FUNCT3_OUT,
  input  logic                      BUSYWAIT
);
  logic       en;
  logic [3:0] ctrl_d, ctrl_q;
  assign en     = ~BUSYWAIT;
  assign ctrl_d = {WRITE_ENABLE_IN, MUXDATAMEM_SELECT_IN, MEM_READ_IN, MEM_WRITE_IN};
  assign {WRITE_ENABLE_OUT, MUXDATAMEM_SELECT_OUT, MEM_READ_OUT, MEM_WRITE_OUT} = ctrl_q;
  pipe_reg_en #(.W(4)) u_ctrl (
    .clk(CLK), .rst_n(RESET), .en(en), .d_i(ctrl_d), .q_o(ctrl_q)
  );
  pipe_reg_en #(.W(DATA_WIDTH)) u_alu (
    .clk(CLK), .rst_n(RESET), .en(en), .d_i(ALU_OUT_IN), .q_o(ALU_OUT_OUT)
  );
  pipe_reg_en #(.W(DATA_WIDTH)) u_out2 (
    .clk(CLK), .rst_n(RESET), .en(en), .d_i(OUT2_IN), .q_o(OUT2_OUT)
  );
  pipe_reg_en #(.W(REG_ADDR_WIDTH)) u_rd (
    .clk(CLK), .rst_n(RESET), .en(en), .d_i(RD_IN), .q_o(RD_OUT)
  );
  pipe_reg_en #(.W(FUNCT3_WIDTH)) u_f3 (
    .clk(CLK), .rst_n(RESET), .en(en), .d_i(FUNCT3_IN), .q_o(FUNCT3_OUT)
  );
endmodule

// File: tb/tb_ex_mem_pipeline_register.sv
// tb_ex_mem_pipeline_register: table-driven and directed checks of the EX/MEM register
module tb_ex_mem_pipeline_register;
  typedef struct packed {
    logic        we, ms, mr, mw;
    logic [31:0] alu, out2;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } fields_t;
  typedef struct {
    logic    rst_n;
    logic    busy;
    fields_t in;
    fields_t exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n, busy;
  logic        we_i, ms_i, mr_i, mw_i;
  logic [31:0] alu_i, out2_i;
  logic [4:0]  rd_i;
  logic [2:0]  f3_i;
  logic        we_o, ms_o, mr_o, mw_o;
  logic [31:0] alu_o, out2_o;
  logic [4:0]  rd_o;
  logic [2:0]  f3_o;
  int          passed = 0;
  int          total = 0;
  vec_t        v[9];
  always #5 clk = ~clk;
  ex_mem_pipeline_register dut (
    .CLK(clk), .RESET(rst_n),
    .WRITE_ENABLE_IN(we_i), .MUXDATAMEM_SELECT_IN(ms_i),
    .MEM_READ_IN(mr_i), .MEM_WRITE_IN(mw_i),
    .ALU_OUT_IN(alu_i), .OUT2_IN(out2_i), .RD_IN(rd_i), .FUNCT3_IN(f3_i),
    .WRITE_ENABLE_OUT(we_o), .MUXDATAMEM_SELECT_OUT(ms_o),
    .MEM_READ_OUT(mr_o), .MEM_WRITE_OUT(mw_o),
    .ALU_OUT_OUT(alu_o), .OUT2_OUT(out2_o), .RD_OUT(rd_o), .FUNCT3_OUT(f3_o),
    .BUSYWAIT(busy)
  );
  function automatic fields_t f(logic we, logic ms, logic mr, logic mw,
                                logic [31:0] alu, logic [31:0] out2,
                                logic [4:0] rd, logic [2:0] f3);
    f = {we, ms, mr, mw, alu, out2, rd, f3};
  endfunction
  task automatic drv(input fields_t x);
    {we_i, ms_i, mr_i, mw_i, alu_i, out2_i, rd_i, f3_i} = x;
  endtask
  task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s %s: got %h, expected %h", tag, fld, act, exp);
  endtask
  task automatic chk(input string tag, input fields_t e);
    cmp(tag, "we",   {31'd0, we_o}, {31'd0, e.we});
    cmp(tag, "ms",   {31'd0, ms_o}, {31'd0, e.ms});
    cmp(tag, "mr",   {31'd0, mr_o}, {31'd0, e.mr});
    cmp(tag, "mw",   {31'd0, mw_o}, {31'd0, e.mw});
    cmp(tag, "alu",  alu_o, e.alu);
    cmp(tag, "out2", out2_o, e.out2);
    cmp(tag, "rd",   {27'd0, rd_o}, {27'd0, e.rd});
    cmp(tag, "f3",   {29'd0, f3_o}, {29'd0, e.f3});
  endtask
  initial begin
    fields_t a, b, c;
    a = f(1, 1, 1, 1, 159, 890, 20, 6);
    b = f(0, 0, 0, 0, 19, 80, 2, 7);
    v[0] = '{1'b0, 1'b0, a, '0};
    v[1] = '{1'b0, 1'b1, a, '0};
    v[2] = '{1'b1, 1'b0, a, a};
    v[3] = '{1'b1, 1'b1, b, a};
    v[4] = '{1'b1, 1'b1, b, a};
    v[5] = '{1'b1, 1'b0, b, b};
    v[6] = '{1'b1, 1'b0, f(1, 0, 0, 1, 1, 32'hA5A5A5A5, 5, 2), f(1, 0, 0, 1, 1, 32'hA5A5A5A5, 5, 2)};
    v[7] = '{1'b1, 1'b0, f(0, 1, 1, 0, 2, 32'h5A5A5A5A, 10, 4), f(0, 1, 1, 0, 2, 32'h5A5A5A5A, 10, 4)};
    v[8] = '{1'b1, 1'b0, f(1, 1, 0, 0, 3, 32'h00000001, 17, 1), f(1, 1, 0, 0, 3, 32'h00000001, 17, 1)};
    rst_n = 1'b0;
    busy = 1'b0;
    drv(a);
    #2 chk("async_reset", '0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst_n = v[i].rst_n;
      busy  = v[i].busy;
      drv(v[i].in);
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), v[i].exp);
    end
    @(negedge clk);
    busy = 1'b1;
    drv(b);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid_stall", '0);
    c = f(0, 0, 0, 0, 32'hFFFFFFFF, 0, 31, 0);
    #1 rst_n = 1'b1;
    busy = 1'b0;
    drv(c);
    @(posedge clk);
    #1 chk("post_reset_capture", c);
    @(negedge clk);
    drv(a);
    #1 busy = 1'b1;
    #1 busy = 1'b0;
    @(posedge clk);
    #1 chk("busy_glitch_ignored", a);
    @(negedge clk);
    busy = 1'b1;
    drv(b);
    @(posedge clk);
    #1 busy = 1'b0;
    #1 chk("busy_at_edge_holds", a);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
